// File: rtl/alm_log_convert_pipe.sv
// Purpose : per-lane integer -> ALM log form (leading-one k, M-bit mantissa, zero, sign).
// Latency : 2 register stages (S1 = magnitude/LOD, S2 = normalise/truncate), 1 txn per cycle.
// Backpr. : valid/ready; S2 holds while out_ready=0, S1 holds while S2 is stalled, nothing dropped.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready         input handshake; in_ready depends on out_ready only
//   in_data[LANES*A_BW]       lane i operand at [i*A_BW +: A_BW]
//   in_comp                   compensated truncation for the whole transaction
//   out_valid/out_ready       output handshake
//   out_k[LANES*LOG2_W]       leading-one position per lane
//   out_frac[LANES*M]         truncated mantissa per lane
//   out_zero[LANES]           operand magnitude is zero
//   out_sign[LANES]           operand sign (0 when SIGNED=0)
module alm_log_convert_pipe #(
    parameter int A_BW   = 16,
    parameter int LANES  = 4,
    parameter int M      = 6,
    parameter int SIGNED = 0,
    parameter int LOG2_W = $clog2(A_BW)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*A_BW-1:0]     in_data,
    input  logic                      in_comp,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LOG2_W-1:0]   out_k,
    output logic [LANES*M-1:0]        out_frac,
    output logic [LANES-1:0]          out_zero,
    output logic [LANES-1:0]          out_sign
);

    typedef struct packed {
        logic [A_BW-1:0]   mag;
        logic [LOG2_W-1:0] k;
        logic              zero;
        logic              sign;
    } s1_lane_t;

    s1_lane_t s1_d [LANES];
    s1_lane_t s1_q [LANES];
    logic     s1_vld;
    logic     s1_comp;
    logic     s1_adv;

    logic [LANES*LOG2_W-1:0] s2_k_d;
    logic [LANES*M-1:0]      s2_frac_d;
    logic [LANES-1:0]        s2_zero_d;
    logic [LANES-1:0]        s2_sign_d;

    // out_valid is the S2 valid bit; S1 may move whenever S2 empties or drains.
    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_vld || s1_adv;

    // ---------------- S1: magnitude, leading-one detect ----------------
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic [A_BW-1:0]   op;
            logic [A_BW-1:0]   mag;
            logic [LOG2_W-1:0] kk;
            logic              neg;
            op  = in_data[i*A_BW +: A_BW];
            neg = (SIGNED != 0) && op[A_BW-1];
            // Two's-complement negate in A_BW bits: the most negative value
            // maps onto itself, which read unsigned is exactly its magnitude.
            mag = neg ? (-op) : op;
            // Priority encoder: the highest set bit wins because it is visited last.
            kk  = '0;
            for (int j = 0; j < A_BW; j++) begin
                if (mag[j]) kk = LOG2_W'(j);
            end
            s1_d[i].mag  = mag;
            s1_d[i].k    = kk;
            s1_d[i].zero = (mag == '0);
            s1_d[i].sign = neg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_comp <= 1'b0;
            for (int i = 0; i < LANES; i++) s1_q[i] <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_q    <= s1_d;
                s1_comp <= in_comp;
            end
        end
    end

    // ---------------- S2: normalise and truncate ----------------
    always_comb begin
        s2_k_d    = '0;
        s2_frac_d = '0;
        s2_zero_d = '0;
        s2_sign_d = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [LOG2_W-1:0] sh;
            logic [A_BW-2:0]   f;
            logic [A_BW-2:0]   rest;
            logic [M-1:0]      fr;
            // Shift the leading one out of the top; what remains is the
            // fraction left-aligned to A_BW-1 bits.
            sh   = LOG2_W'(A_BW-1) - s1_q[i].k;
            f    = (A_BW-1)'(s1_q[i].mag << sh);
            // Bits below the kept mantissa; empty when M = A_BW-1.
            rest = f << M;
            fr   = f[A_BW-2 -: M];
            if (s1_comp && (rest != '0)) fr[0] = 1'b1;
            s2_k_d[i*LOG2_W +: LOG2_W] = s1_q[i].k;
            s2_frac_d[i*M +: M]        = fr;
            s2_zero_d[i]               = s1_q[i].zero;
            s2_sign_d[i]               = s1_q[i].sign;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_k     <= '0;
            out_frac  <= '0;
            out_zero  <= '0;
            out_sign  <= '0;
        end else if (s1_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_k    <= s2_k_d;
                out_frac <= s2_frac_d;
                out_zero <= s2_zero_d;
                out_sign <= s2_sign_d;
            end
        end
    end

endmodule

// File: tb/tb_alm_log_convert_pipe.sv
// Purpose : self-checking bench for alm_log_convert_pipe (unsigned 4-lane, signed 4-lane, 8-bit sweep).
// Latency : n/a (testbench).
// Backpr. : drives random and patterned out_ready to stall the design.
module tb_alm_log_convert_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Unsigned 4-lane instance
    logic        in_valid, in_ready, in_comp, out_valid, out_ready;
    logic [63:0] in_data;
    logic [15:0] out_k;
    logic [23:0] out_frac;
    logic [3:0]  out_zero, out_sign;

    // Signed 4-lane instance
    logic        sg_in_valid, sg_in_ready, sg_in_comp, sg_out_valid, sg_out_ready;
    logic [63:0] sg_in_data;
    logic [15:0] sg_out_k;
    logic [23:0] sg_out_frac;
    logic [3:0]  sg_out_zero, sg_out_sign;

    // 8-bit single-lane sweep instance
    logic        sw_in_valid, sw_in_ready, sw_in_comp, sw_out_valid, sw_out_ready;
    logic [7:0]  sw_in_data;
    logic [2:0]  sw_out_k;
    logic [2:0]  sw_out_frac;
    logic [0:0]  sw_out_zero, sw_out_sign;

    alm_log_convert_pipe #(.A_BW(16), .LANES(4), .M(6), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_comp(in_comp), .out_valid(out_valid),
        .out_ready(out_ready), .out_k(out_k), .out_frac(out_frac),
        .out_zero(out_zero), .out_sign(out_sign));

    alm_log_convert_pipe #(.A_BW(16), .LANES(4), .M(6), .SIGNED(1)) u_sg (
        .clk(clk), .rst(rst), .in_valid(sg_in_valid), .in_ready(sg_in_ready),
        .in_data(sg_in_data), .in_comp(sg_in_comp), .out_valid(sg_out_valid),
        .out_ready(sg_out_ready), .out_k(sg_out_k), .out_frac(sg_out_frac),
        .out_zero(sg_out_zero), .out_sign(sg_out_sign));

    alm_log_convert_pipe #(.A_BW(8), .LANES(1), .M(3), .SIGNED(0)) u_sw (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready),
        .in_data(sw_in_data), .in_comp(sw_in_comp), .out_valid(sw_out_valid),
        .out_ready(sw_out_ready), .out_k(sw_out_k), .out_frac(sw_out_frac),
        .out_zero(sw_out_zero), .out_sign(sw_out_sign));

    typedef struct packed {
        logic [63:0] k;
        logic [63:0] frac;
        logic [7:0]  zero;
        logic [7:0]  sign;
    } exp_t;

    typedef struct packed {
        logic [63:0] data;
        logic        comp;
    } txn_t;

    txn_t q_main[$];
    txn_t q_sg[$];
    txn_t q_sw[$];

    int checks = 0;
    int errors = 0;
    int npop = 0;
    int sw_npop = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: leading one by repeated halving, mantissa as the scaled
    // remainder below the leading power of two.
    function automatic exp_t model(input logic [63:0] data, input logic comp,
                                   input int abw, input int lanes, input int m, input int sgn);
        exp_t e;
        int   lw;
        e  = '0;
        lw = 0;
        while ((1 << lw) < abw) lw++;
        for (int i = 0; i < lanes; i++) begin
            longint a, mag, rem, sc, fr;
            int     k;
            bit     neg;
            a   = longint'((data >> (i*abw)) & ((64'd1 << abw) - 64'd1));
            neg = (sgn != 0) && (a >= (longint'(1) << (abw-1)));
            mag = neg ? ((longint'(1) << abw) - a) : a;
            k   = 0;
            while ((mag >> (k+1)) != 0) k++;
            fr = 0;
            if (mag != 0) begin
                rem = mag - (longint'(1) << k);
                sc  = rem << m;
                fr  = sc >> k;
                if (comp && ((sc % (longint'(1) << k)) != 0)) fr = fr | 1;
            end
            e.k       |= 64'(k) << (i*lw);
            e.frac    |= 64'(fr) << (i*m);
            e.zero[i]  = (mag == 0);
            e.sign[i]  = neg;
        end
        return e;
    endfunction

    function automatic logic [15:0] rnd_lane();
        logic [15:0] v;
        v = 16'($urandom);
        v = v >> $urandom_range(16, 0);
        if ($urandom_range(3, 0) == 0) v = ~v;
        return v;
    endfunction

    // ---------------- compare process: unsigned instance ----------------
    bit          held = 1'b0;
    logic [48:0] held_val;
    always @(negedge clk) begin
        if (rst) begin
            q_main.delete();
            held = 1'b0;
        end else begin
            exp_t e;
            txn_t t;
            chk("in_ready", in_ready, !(q_main.size() == 2 && !out_ready));
            if (q_main.size() == 0) chk("idle_out_valid", out_valid, 0);
            if (held) chk("hold_stable", {out_valid, out_k, out_frac, out_zero, out_sign}, held_val);
            if (out_valid && out_ready) begin
                chk("out_has_txn", q_main.size() != 0, 1);
                if (q_main.size() != 0) begin
                    t = q_main.pop_front();
                    e = model(t.data, t.comp, 16, 4, 6, 0);
                    chk("main_k", out_k, e.k[15:0]);
                    chk("main_frac", out_frac, e.frac[23:0]);
                    chk("main_zero", out_zero, e.zero[3:0]);
                    chk("main_sign", out_sign, e.sign[3:0]);
                    npop++;
                end
            end
            held     = out_valid && !out_ready;
            held_val = {out_valid, out_k, out_frac, out_zero, out_sign};
            if (in_valid && in_ready) q_main.push_back('{data: in_data, comp: in_comp});
        end
    end

    // ---------------- compare process: signed instance ----------------
    always @(negedge clk) begin
        if (rst) begin
            q_sg.delete();
        end else begin
            exp_t e;
            txn_t t;
            if (sg_out_valid && sg_out_ready) begin
                chk("sg_has_txn", q_sg.size() != 0, 1);
                if (q_sg.size() != 0) begin
                    t = q_sg.pop_front();
                    e = model(t.data, t.comp, 16, 4, 6, 1);
                    chk("sg_k", sg_out_k, e.k[15:0]);
                    chk("sg_frac", sg_out_frac, e.frac[23:0]);
                    chk("sg_zero", sg_out_zero, e.zero[3:0]);
                    chk("sg_sign", sg_out_sign, e.sign[3:0]);
                end
            end
            if (sg_in_valid && sg_in_ready) q_sg.push_back('{data: sg_in_data, comp: sg_in_comp});
        end
    end

    // ---------------- compare process: 8-bit sweep instance ----------------
    always @(negedge clk) begin
        if (rst) begin
            q_sw.delete();
        end else begin
            exp_t e;
            txn_t t;
            if (sw_out_valid && sw_out_ready) begin
                chk("sw_has_txn", q_sw.size() != 0, 1);
                if (q_sw.size() != 0) begin
                    t = q_sw.pop_front();
                    e = model(t.data, t.comp, 8, 1, 3, 0);
                    chk("sw_k", sw_out_k, e.k[2:0]);
                    chk("sw_frac", sw_out_frac, e.frac[2:0]);
                    chk("sw_zero", sw_out_zero, e.zero[0:0]);
                    sw_npop++;
                end
            end
            if (sw_in_valid && sw_in_ready) q_sw.push_back('{data: {56'd0, sw_in_data}, comp: sw_in_comp});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction on the unsigned instance with literal expectations.
    task automatic send_main(input string nm, input logic [63:0] d, input logic c,
                             input logic [15:0] ek, input logic [23:0] ef, input logic [3:0] ez);
        in_data   = d;
        in_comp   = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({nm, "_s1_only"}, out_valid, 0);
        tick();
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_k"}, out_k, ek);
        chk({nm, "_frac"}, out_frac, ef);
        chk({nm, "_zero"}, out_zero, ez);
        chk({nm, "_sign"}, out_sign, 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        exp_t pe;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_comp = 1'b0; out_ready = 1'b1;
        sg_in_valid = 1'b0; sg_in_data = '0; sg_in_comp = 1'b0; sg_out_ready = 1'b1;
        sw_in_valid = 1'b0; sw_in_data = '0; sw_in_comp = 1'b0; sw_out_ready = 1'b1;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_k", out_k, 0);
        chk("rst_out_frac", out_frac, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_sign", out_sign, 0);
        chk("rst_sg_valid", sg_out_valid, 0);
        chk("rst_sw_valid", sw_out_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);

        // Pin the reference model against hand-computed values.
        pe = model(64'h0000_00FF_0123_0B40, 1'b0, 16, 4, 6, 0);
        chk("pin_k", pe.k, {4'd0, 4'd7, 4'd8, 4'd11});
        chk("pin_frac", pe.frac, {6'b000000, 6'b111111, 6'b001000, 6'b011010});
        pe = model(64'h0000_00FF_0123_0B40, 1'b1, 16, 4, 6, 0);
        chk("pin_frac_comp", pe.frac, {6'b000000, 6'b111111, 6'b001001, 6'b011010});
        pe = model(64'h0001_0005_8000_FFFB, 1'b0, 16, 4, 6, 1);
        chk("pin_sg_k", pe.k, {4'd0, 4'd2, 4'd15, 4'd2});
        chk("pin_sg_sign", pe.sign, 8'b0000_0011);

        // Basic conversion and compensation.
        send_main("basic", 64'h0000_00FF_0123_0B40, 1'b0, {4'd0, 4'd7, 4'd8, 4'd11},
                  {6'b000000, 6'b111111, 6'b001000, 6'b011010}, 4'b1000);
        send_main("comp", 64'h0000_00FF_0123_0B40, 1'b1, {4'd0, 4'd7, 4'd8, 4'd11},
                  {6'b000000, 6'b111111, 6'b001001, 6'b011010}, 4'b1000);

        // Backpressure: 8 transactions, out_ready pattern 1,0,0,1.
        begin
            int acc = 0, cyc = 0, lowcnt = 0, n0;
            bit a;
            n0 = npop;
            in_valid = 1'b1;
            while (acc < 8 && cyc < 200) begin
                in_data   = {16'(acc*4099 + 3), 16'(acc << 5), 16'(16'h8000 >> acc), 16'(acc)};
                in_comp   = acc[0];
                out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                @(negedge clk);
                a = in_valid && in_ready;
                if (!in_ready) lowcnt++;
                @(posedge clk);
                #1;
                if (a) acc++;
                cyc++;
            end
            in_valid = 1'b0;
            chk("bp_accepted", acc, 8);
            chk("bp_in_ready_dropped", lowcnt > 0, 1);
            out_ready = 1'b1;
            for (int i = 0; i < 20 && npop < n0 + 8; i++) tick();
            chk("bp_emitted", npop - n0, 8);
        end

        // Random stream with random stalls.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            in_comp   = $urandom_range(1, 0) != 0;
            for (int l = 0; l < 4; l++) in_data[l*16 +: 16] = rnd_lane();
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("rand_drained", q_main.size(), 0);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h1234_0F0F_00A5_7FFF;
        repeat (3) tick();
        chk("pre_rst_full", {out_valid, in_ready}, 2'b10);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_k", out_k, 0);
        chk("rst_async_in_ready", in_ready, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        send_main("post_rst", 64'h0000_00FF_0123_0B40, 1'b0, {4'd0, 4'd7, 4'd8, 4'd11},
                  {6'b000000, 6'b111111, 6'b001000, 6'b011010}, 4'b1000);

        // Signed instance: literal case, then random.
        sg_in_data  = 64'h0001_0005_8000_FFFB;
        sg_in_comp  = 1'b0;
        sg_in_valid = 1'b1;
        tick();
        sg_in_valid = 1'b0;
        tick();
        chk("sg_lit_valid", sg_out_valid, 1);
        chk("sg_lit_k", sg_out_k, {4'd0, 4'd2, 4'd15, 4'd2});
        chk("sg_lit_frac", sg_out_frac, {6'b000000, 6'b010000, 6'b000000, 6'b010000});
        chk("sg_lit_sign", sg_out_sign, 4'b0011);
        chk("sg_lit_zero", sg_out_zero, 4'b0000);
        tick();
        for (int c = 0; c < 150; c++) begin
            sg_in_valid = $urandom_range(1, 0) != 0;
            sg_in_comp  = $urandom_range(1, 0) != 0;
            for (int l = 0; l < 4; l++) sg_in_data[l*16 +: 16] = rnd_lane();
            tick();
        end
        sg_in_valid = 1'b0;
        repeat (4) tick();
        chk("sg_drained", q_sg.size(), 0);

        // Exhaustive 8-bit sweep, both compensation modes.
        for (int v = 0; v < 512; v++) begin
            sw_in_valid = 1'b1;
            sw_in_data  = v[7:0];
            sw_in_comp  = v[8];
            tick();
        end
        sw_in_valid = 1'b0;
        repeat (4) tick();
        chk("sw_drained", q_sw.size(), 0);
        chk("sw_count", sw_npop, 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alm_log_convert_pipe.md
Name: alm_log_convert_pipe

Overview:
- Pipelined, multi-lane successor to the combinational ALM operand pre-approximation stage.
- Per lane, converts an integer operand into ALM log form:
  - characteristic k, the position of the leading one;
  - mantissa truncated to M bits, with optional compensation;
  - zero flag and sign bit.
- Sits between the operand feeders and the ALM fraction adder/antilog stage of the approximate PE array.
- Uses a valid/ready handshake so the PE array can stall it.

Parameters:
- A_BW, 16, operand width per lane (≥4).
- LANES, 4, number of parallel operands converted per transaction.
- M, 6, retained mantissa bits; 1 ≤ M ≤ A_BW-1.
- SIGNED, 0, 1 = operands are two's complement; magnitude is converted and sign is reported.
- LOG2_W, $clog2(A_BW), width of k.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block accepts a transaction this cycle.
- in_data  in  LANES*A_BW  operands; lane i is bits [i*A_BW +: A_BW].
- in_comp  in  1  1 = compensated truncation for this transaction.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  consumer accepts the output.
- out_k  out  LANES*LOG2_W  leading-one position per lane.
- out_frac  out  LANES*M  truncated mantissa per lane.
- out_zero  out  LANES  operand magnitude is 0.
- out_sign  out  LANES  operand sign; always 0 when SIGNED=0.

Behaviour:
- Reset values:
  - out_valid=0, out_k=0, out_frac=0, out_zero=0, out_sign=0.
  - All internal stage valid bits are 0.
  - in_ready=1 after reset.
- Pipeline: two register stages, S1 and S2; S2 drives the outputs.
  - Latency is 2 cycles from the accepting edge to out_valid when there is no stall.
  - Throughput is one transaction per cycle.
- Handshake rules:
  - Transfer occurs when valid && ready is high at the rising clk edge.
  - in_ready = !s1_valid || s1_adv, where s1_adv = !s2_valid || out_ready. in_ready is combinational from out_ready and carries no combinational path from in_valid.
  - While out_valid=1 && out_ready=0, all out_* signals hold stable.
  - S1 holds its contents whenever S2 is stalled.
  - No transaction is ever dropped or duplicated.
- S1 (per lane):
  - mag = SIGNED ? |A| : A, computed as an A_BW-bit unsigned value; -2^(A_BW-1) gives mag = 2^(A_BW-1).
  - sign = SIGNED & A[A_BW-1].
  - k = index of the most significant 1 in mag, found by LOD plus priority encoder.
  - zero = (mag==0).
  - S1 registers mag, k, zero, sign and in_comp.
- S2 (per lane):
  - f = mag shifted left by (A_BW-1-k), taking bits [A_BW-2:0]. This is the fraction below the leading one, left-aligned to A_BW-1 bits.
  - frac = f[A_BW-2 -: M].
  - When comp=1 and any discarded bit f[A_BW-2-M:0] is nonzero, frac LSB is forced to 1.
  - When M = A_BW-1 no bits are discarded and comp has no effect.
- Zero operand: out_k=0, out_frac=0, out_zero=1. out_sign is 0, because -0 does not exist.
- mag=1: k=0, frac=0, zero=0.
- Lanes are fully independent; in_comp applies to all lanes of its transaction.
- Reset asserted mid-operation: both stages are cleared asynchronously and in-flight transactions are discarded. The first acceptance occurs after rst deassertion.
- Simultaneous events:
  - A full pipeline with out_ready=1 and in_valid=1 accepts, advances and emits in the same cycle.
  - in_valid may deassert at any time without corrupting held data.

Test Plan:
- Basic lane conversion: A_BW=16, M=6, SIGNED=0, comp=0; lanes {0x0B40, 0x0123, 0x00FF, 0x0000} -> 2 cycles later:
  - k = {11, 8, 7, 0};
  - frac = {011010, 001000, 111111, 000000};
  - zero = {0, 0, 0, 1}.
- Compensation: same operands with comp=1 -> frac = {011010, 001001, 111111, 000000}.
  - 0x0B40 is unchanged because no discarded bits are set.
  - 0x0123 gets its LSB set.
- Signed mode: SIGNED=1, lanes {0xFFFB, 0x8000, 0x0005, 0x0001} ->
  - k = {2, 15, 2, 0};
  - frac = {010000, 000000, 010000, 000000};
  - sign = {1, 1, 0, 0}.
- Backpressure: stream 8 transactions with in_valid held high, out_ready toggling 1,0,0,1,... -> all 8 emerge in order with no loss or duplication.
  - Outputs stay stable while stalled.
  - in_ready drops only when both stages are full and out_ready=0.
- Reset mid-stream: assert rst with both stages valid -> out_valid=0 immediately, with no clock edge required.
  - After release, the next accepted transaction appears 2 cycles later with correct values.
- Exhaustive single-lane sweep: A_BW=8, M=3, all 256 operands in both comp modes -> matches the reference model for k, frac and zero.
